alu_cmd_sequencer: RTL and testbench

//   Upstream issue stage for the 32-bit combinational ALU. Accepts tagged commands over valid/ready,

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_cmd_sequencer_if.sv | 55 +++++
 rtl/alu_cmd_fifo.sv | 59 +++++
 rtl/alu_cmd_sequencer.sv | 154 +++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU command sequencer: opcodes, queued command record, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

    localparam int DATA_W    = 32;
    // Tag width carried through the command queue; instances using a wider tag need this raised.
    localparam int CMD_TAG_W = 4;

    typedef enum logic [2:0] {
        ADD  = 3'b000,
        SUB  = 3'b001,
        INC  = 3'b010,
        DEC  = 3'b011,
        PASS = 3'b100,
        NOT  = 3'b101,
        OR   = 3'b110,
        AND  = 3'b111
    } alu_op_e;

    typedef struct packed {
        logic [DATA_W-1:0]    a;
        logic [DATA_W-1:0]    b;
        alu_op_e              op;
        logic [CMD_TAG_W-1:0] tag;
    } alu_cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        RESP  = 2'b10
    } seq_state_e;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Bundles the command, ALU-side and response signals of the sequencer.
// Latency: n/a (wiring only).
// Backpressure: cmd_valid/cmd_ready and rsp_valid/rsp_ready handshakes.
interface alu_cmd_sequencer_if
    import alu_pkg::*;
#(
    parameter int TAG_W = 4,
    parameter int LVL_W = 3
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [DATA_W-1:0]     cmd_a;
    logic [DATA_W-1:0]     cmd_b;
    alu_op_e               cmd_op;
    logic [TAG_W-1:0]      cmd_tag;

    logic [DATA_W-1:0]     alu_a;
    logic [DATA_W-1:0]     alu_b;
    alu_op_e               alu_opcode;
    logic                  alu_enable;
    logic [DATA_W-1:0]     alu_result;
    logic                  alu_ack;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rsp_data;
    logic [TAG_W-1:0]      rsp_tag;
    logic                  rsp_err;

    logic [LVL_W-1:0]      fifo_level;
    logic                  busy;

    // Sequencer side.
    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag,
        output cmd_ready,
        output alu_a, alu_b, alu_opcode, alu_enable,
        input  alu_result, alu_ack,
        output rsp_valid, rsp_data, rsp_tag, rsp_err,
        input  rsp_ready,
        output fifo_level, busy
    );

    // Command producer / ALU / response consumer side.
    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag,
        input  cmd_ready,
        input  alu_a, alu_b, alu_opcode, alu_enable,
        output alu_result, alu_ack,
        input  rsp_valid, rsp_data, rsp_tag, rsp_err,
        output rsp_ready,
        input  fifo_level, busy
    );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO of alu_cmd_t with an occupancy count; head entry visible combinationally.
// Latency: a pushed entry is visible at the head one cycle after the push edge.
// Backpressure: caller must not push when full or pop when empty; level drives that decision.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  alu_cmd_t                   wr_dat,
    input  logic                       pop,
    output alu_cmd_t                   rd_dat,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int PTR_W = $clog2(DEPTH);

    alu_cmd_t               mem_q [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]         level_q, level_d;

    // Pointer and level updates; power-of-two depth makes pointer increment wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents are don't-care until written, so it carries no reset.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_dat;
    end

    assign rd_dat = mem_q[rd_ptr_q];
    assign level  = level_q;

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Queues tagged ALU commands, issues them one at a time and returns results in order, flagging ack timeouts.
// Latency: command accepted in cycle t -> ALU enabled in t+2 -> response valid from t+3 when ALU acks at once.
// Backpressure: cmd_ready drops when the queue is full; a held response stalls issue of the next command.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int TAG_W       = CMD_TAG_W,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_cmd_sequencer_if.slave   bus
);
    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(ACK_TIMEOUT);

    seq_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    alu_op_e             op_q, op_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic [TAG_W-1:0]    rsp_tag_q, rsp_tag_d;
    logic                rsp_err_q, rsp_err_d;

    logic                cmd_ready_int;
    logic                push;
    logic                pop;
    alu_cmd_t            wr_cmd;
    alu_cmd_t            head;
    logic [LVL_W-1:0]    level;

    // Ready uses the registered level only: a pop in the same cycle does not reopen a full queue.
    assign cmd_ready_int = !rst && (level < FULL_LVL);
    assign push          = bus.cmd_valid && cmd_ready_int;

    // Pack the incoming command into a queue entry.
    always_comb begin
        wr_cmd     = '0;
        wr_cmd.a   = bus.cmd_a;
        wr_cmd.b   = bus.cmd_b;
        wr_cmd.op  = bus.cmd_op;
        wr_cmd.tag = CMD_TAG_W'(bus.cmd_tag);
    end

    alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (push),
        .wr_dat (wr_cmd),
        .pop    (pop),
        .rd_dat (head),
        .level  (level)
    );

    // Next-state logic: pop into the issue registers, wait for ack or timeout, hold the response.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        tag_d      = tag_q;
        rsp_data_d = rsp_data_q;
        rsp_tag_d  = rsp_tag_q;
        rsp_err_d  = rsp_err_q;
        pop        = 1'b0;
        case (state_q)
            IDLE: begin
                if (level != '0) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.alu_ack) begin
                    rsp_data_d = bus.alu_result;
                    rsp_err_d  = 1'b0;
                    rsp_tag_d  = tag_q;
                    state_d    = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CNT_MAX) begin
                        rsp_data_d = '0;
                        rsp_err_d  = 1'b1;
                        rsp_tag_d  = tag_q;
                        state_d    = RESP;
                    end
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    if (level != '0) begin
                        pop     = 1'b1;
                        state_d = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Every pop starts a fresh ISSUE with the head command and a cleared timeout count.
        if (pop) begin
            a_d   = head.a;
            b_d   = head.b;
            op_d  = head.op;
            tag_d = TAG_W'(head.tag);
            cnt_d = '0;
        end
    end

    // State, issue and response registers; reset drops any in-flight or pending work.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= ADD;
            tag_q      <= '0;
            rsp_data_q <= '0;
            rsp_tag_q  <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            tag_q      <= tag_d;
            rsp_data_q <= rsp_data_d;
            rsp_tag_q  <= rsp_tag_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign bus.cmd_ready  = cmd_ready_int;
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.alu_opcode = op_q;
    assign bus.alu_enable = (state_q == ISSUE);
    assign bus.rsp_valid  = (state_q == RESP);
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_tag    = rsp_tag_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.fifo_level = level;
    assign bus.busy       = (state_q != IDLE) || (level != '0);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural ALU whose ack can be disabled.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: rsp_ready and the ALU ack are driven per scenario.
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    logic clk;
    logic rst;
    logic ack_on;
    int   tests_run;
    int   tests_failed;

    alu_cmd_sequencer_if #(.TAG_W(4), .LVL_W(3)) bus ();

    alu_cmd_sequencer #(.DEPTH(4), .TAG_W(4), .ACK_TIMEOUT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural combinational ALU.
    always_comb begin
        case (bus.alu_opcode)
            ADD:     bus.alu_result = bus.alu_a + bus.alu_b;
            SUB:     bus.alu_result = bus.alu_a - bus.alu_b;
            INC:     bus.alu_result = bus.alu_a + 32'd1;
            DEC:     bus.alu_result = bus.alu_a - 32'd1;
            PASS:    bus.alu_result = bus.alu_a;
            NOT:     bus.alu_result = ~bus.alu_a;
            OR:      bus.alu_result = bus.alu_a | bus.alu_b;
            default: bus.alu_result = bus.alu_a & bus.alu_b;
        endcase
    end
    assign bus.alu_ack = bus.alu_enable && ack_on;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a command and hold it until the edge that accepts it.
    task automatic push_cmd(input logic [31:0] a, input logic [31:0] b, input alu_op_e op,
                            input logic [3:0] tag, output bit ok);
        int n;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_op    = op;
        bus.cmd_tag   = tag;
        bus.cmd_valid = 1'b1;
        ok = 1'b0;
        n  = 0;
        while (!bus.cmd_ready && n < 50) begin
            step();
            n++;
        end
        if (bus.cmd_ready) begin
            ok = 1'b1;
            step();
        end
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output bit ok);
        int n;
        n = 0;
        while (!bus.rsp_valid && n < 50) begin
            step();
            n++;
        end
        ok = bus.rsp_valid;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        tests_run++;
        if (bus.cmd_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_cmd_ready got %b want 0", bus.cmd_ready); end
        tests_run++;
        if ({bus.alu_enable, bus.rsp_valid, bus.rsp_err, bus.busy} !== 4'b0000) begin
            tests_failed++; $display("FAIL reset_flags got %b want 0000", {bus.alu_enable, bus.rsp_valid, bus.rsp_err, bus.busy});
        end
        tests_run++;
        if ({bus.alu_a, bus.alu_b, bus.rsp_data} !== 96'd0 || bus.rsp_tag !== 4'd0 || bus.fifo_level !== 3'd0) begin
            tests_failed++; $display("FAIL reset_regs got a=%h b=%h d=%h tag=%h lvl=%0d want all 0",
                bus.alu_a, bus.alu_b, bus.rsp_data, bus.rsp_tag, bus.fifo_level);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (bus.cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_release_ready got %b want 1", bus.cmd_ready); end
    endtask

    task automatic test_add_latency();
        bus.rsp_ready = 1'b1;
        bus.cmd_a = 32'd5; bus.cmd_b = 32'd7; bus.cmd_op = ADD; bus.cmd_tag = 4'd1;
        bus.cmd_valid = 1'b1;
        step();
        bus.cmd_valid = 1'b0;
        tests_run++;
        if (bus.fifo_level !== 3'd1 || bus.rsp_valid !== 1'b0) begin
            tests_failed++; $display("FAIL add_t1 got lvl=%0d rsp_valid=%b want 1,0", bus.fifo_level, bus.rsp_valid);
        end
        step();
        tests_run++;
        if (bus.alu_enable !== 1'b1 || bus.alu_a !== 32'd5 || bus.alu_b !== 32'd7 || bus.alu_opcode !== ADD || bus.rsp_valid !== 1'b0) begin
            tests_failed++; $display("FAIL add_t2_issue got en=%b a=%0d b=%0d op=%0d rv=%b want 1,5,7,0,0",
                bus.alu_enable, bus.alu_a, bus.alu_b, bus.alu_opcode, bus.rsp_valid);
        end
        step();
        tests_run++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'd12 || bus.rsp_tag !== 4'd1 || bus.rsp_err !== 1'b0) begin
            tests_failed++; $display("FAIL add_t3_rsp got v=%b d=%0d tag=%0d err=%b want 1,12,1,0",
                bus.rsp_valid, bus.rsp_data, bus.rsp_tag, bus.rsp_err);
        end
        step();
        tests_run++;
        if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
            tests_failed++; $display("FAIL add_done got rv=%b busy=%b want 0,0", bus.rsp_valid, bus.busy);
        end
    endtask

    task automatic test_sub_not();
        bit ok;
        bus.rsp_ready = 1'b1;
        push_cmd(32'd0, 32'd1, SUB, 4'd2, ok);
        wait_rsp(ok);
        tests_run++;
        if (!ok || bus.rsp_data !== 32'hFFFF_FFFF || bus.rsp_tag !== 4'd2) begin
            tests_failed++; $display("FAIL sub_wrap got ok=%b d=%h tag=%0d want 1,ffffffff,2", ok, bus.rsp_data, bus.rsp_tag);
        end
        step();
        push_cmd(32'h0000_FFFF, 32'd0, NOT, 4'd3, ok);
        wait_rsp(ok);
        tests_run++;
        if (!ok || bus.rsp_data !== 32'hFFFF_0000 || bus.rsp_tag !== 4'd3) begin
            tests_failed++; $display("FAIL not_op got ok=%b d=%h tag=%0d want 1,ffff0000,3", ok, bus.rsp_data, bus.rsp_tag);
        end
        step();
    endtask

    task automatic test_full_backpressure();
        int  idx;
        bit  acc;
        bit  ok;
        int  exp_tag;
        bus.rsp_ready = 1'b0;
        idx = 0;
        bus.cmd_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (idx < 8) begin
                bus.cmd_a = 32'h100 + 32'(idx); bus.cmd_b = 32'd0; bus.cmd_op = PASS; bus.cmd_tag = 4'(idx);
                acc = bus.cmd_ready;
                step();
                if (acc) idx++;
            end
        end
        bus.cmd_valid = 1'b0;
        tests_run++;
        if (idx !== 5) begin tests_failed++; $display("FAIL full_accept_count got %0d want 5", idx); end
        tests_run++;
        if (bus.cmd_ready !== 1'b0 || bus.fifo_level !== 3'd4) begin
            tests_failed++; $display("FAIL full_ready got rdy=%b lvl=%0d want 0,4", bus.cmd_ready, bus.fifo_level);
        end
        tests_run++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_tag !== 4'd0 || bus.rsp_data !== 32'h100) begin
            tests_failed++; $display("FAIL full_first_rsp got v=%b tag=%0d d=%h want 1,0,100", bus.rsp_valid, bus.rsp_tag, bus.rsp_data);
        end
        bus.rsp_ready = 1'b1;
        step();
        tests_run++;
        if (bus.cmd_ready !== 1'b1 || bus.fifo_level !== 3'd3) begin
            tests_failed++; $display("FAIL full_ready_reassert got rdy=%b lvl=%0d want 1,3", bus.cmd_ready, bus.fifo_level);
        end
        for (exp_tag = 1; exp_tag < 5; exp_tag++) begin
            wait_rsp(ok);
            tests_run++;
            if (!ok || bus.rsp_tag !== 4'(exp_tag) || bus.rsp_data !== 32'h100 + 32'(exp_tag)) begin
                tests_failed++; $display("FAIL full_order got ok=%b tag=%0d d=%h want tag %0d d=%h",
                    ok, bus.rsp_tag, bus.rsp_data, exp_tag, 32'h100 + 32'(exp_tag));
            end
            step();
        end
        tests_run++;
        if (bus.fifo_level !== 3'd0 || bus.busy !== 1'b0) begin
            tests_failed++; $display("FAIL full_drained got lvl=%0d busy=%b want 0,0", bus.fifo_level, bus.busy);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int en_cnt;
        ack_on = 1'b0;
        bus.rsp_ready = 1'b0;
        push_cmd(32'd1, 32'd2, ADD, 4'd9, ok);
        en_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            if (!bus.rsp_valid) begin
                step();
                if (bus.alu_enable) en_cnt++;
            end
        end
        tests_run++;
        if (!ok || en_cnt !== 8) begin tests_failed++; $display("FAIL timeout_enable_cycles got %0d want 8", en_cnt); end
        tests_run++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_data !== 32'd0 || bus.rsp_tag !== 4'd9) begin
            tests_failed++; $display("FAIL timeout_rsp got v=%b err=%b d=%h tag=%0d want 1,1,0,9",
                bus.rsp_valid, bus.rsp_err, bus.rsp_data, bus.rsp_tag);
        end
        bus.rsp_ready = 1'b1;
        step();
        ack_on = 1'b1;
    endtask

    task automatic test_back_to_back();
        bit ok;
        int hs;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_cmd(32'(20 * i), 32'd0, INC, 4'(10 + i), ok);
        wait_rsp(ok);
        tests_run++;
        if (!ok || bus.fifo_level !== 3'd3) begin tests_failed++; $display("FAIL b2b_queued got ok=%b lvl=%0d want 1,3", ok, bus.fifo_level); end
        bus.rsp_ready = 1'b1;
        hs = 0;
        for (int c = 0; c < 12; c++) begin
            if (bus.rsp_valid) begin
                tests_run++;
                if (c !== 2 * hs || bus.rsp_tag !== 4'(10 + hs) || bus.rsp_data !== 32'(20 * hs + 1)) begin
                    tests_failed++; $display("FAIL b2b_hs got cyc=%0d tag=%0d d=%0d want cyc=%0d tag=%0d d=%0d",
                        c, bus.rsp_tag, bus.rsp_data, 2 * hs, 10 + hs, 20 * hs + 1);
                end
                hs++;
            end
            step();
        end
        tests_run++;
        if (hs !== 4) begin tests_failed++; $display("FAIL b2b_count got %0d want 4", hs); end
    endtask

    task automatic test_reset_mid_op();
        bit ok;
        int stale;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_cmd(32'd7, 32'd3, OR, 4'(4 + i), ok);
        wait_rsp(ok);
        tests_run++;
        if (!ok || bus.fifo_level !== 3'd2) begin tests_failed++; $display("FAIL rstmid_setup got ok=%b lvl=%0d want 1,2", ok, bus.fifo_level); end
        rst = 1'b1;
        #1;
        tests_run++;
        if (bus.cmd_ready !== 1'b0) begin tests_failed++; $display("FAIL rstmid_ready got %b want 0", bus.cmd_ready); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        tests_run++;
        if (bus.rsp_valid !== 1'b0 || bus.fifo_level !== 3'd0 || bus.alu_enable !== 1'b0 || bus.busy !== 1'b0) begin
            tests_failed++; $display("FAIL rstmid_clear got rv=%b lvl=%0d en=%b busy=%b want 0,0,0,0",
                bus.rsp_valid, bus.fifo_level, bus.alu_enable, bus.busy);
        end
        bus.rsp_ready = 1'b1;
        stale = 0;
        for (int c = 0; c < 15; c++) begin
            step();
            if (bus.rsp_valid) stale++;
        end
        tests_run++;
        if (stale !== 0) begin tests_failed++; $display("FAIL rstmid_stale got %0d responses want 0", stale); end
    endtask

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        ack_on        = 1'b1;
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.cmd_op    = ADD;
        bus.cmd_tag   = '0;
        bus.rsp_ready = 1'b0;
        #1;
        test_reset();
        test_add_latency();
        test_sub_not();
        test_full_backpressure();
        test_timeout();
        test_back_to_back();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
